// File: rtl/rriot_bus_arbiter.sv
// rriot_bus_arbiter
//   Shares one RRIOT device port between a CPU and a host requester.
//   Each transaction is IDLE -> ACCESS -> COMPLETE. The CPU normally wins
//   arbitration, but a waiting host is guaranteed service once it has been
//   bypassed for HOST_MAX_WAIT cycles.
//
// Ports
//   clk, rst_n          : rising-edge clock (device phi2); synchronous active-low reset
//   cpu_req/we_n/rom    : CPU request, write strobe (active low), ROM select
//   cpu_addr/wdata      : CPU address (10b) and write data (8b)
//   cpu_ack/rdata       : CPU completion pulse and captured read data
//   host_*              : same set for the host requester
//   dev_we_n/A/DI       : device write strobe, address, write data
//   dev_RS0/dev_CS1     : device RAM/IO select and ROM select
//   dev_DO/dev_OE       : device read data and its output-enable
//   bus_err             : one-cycle pulse when a read found dev_OE low
module rriot_bus_arbiter #(
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_we_n,
  input  logic       cpu_rom,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       host_req,
  input  logic       host_we_n,
  input  logic       host_rom,
  input  logic [9:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       dev_we_n,
  output logic [9:0] dev_A,
  output logic [7:0] dev_DI,
  output logic       dev_RS0,
  output logic       dev_CS1,
  input  logic [7:0] dev_DO,
  input  logic       dev_OE,
  output logic       bus_err
);

  localparam int         DATA_W  = 8;
  localparam logic [3:0] MAX_CNT = 4'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]        host_wait_cnt;
  logic              owner;        // 1 = host owns the current transaction
  logic              we_n_q;
  logic              rom_q;
  logic [9:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic grant;
  logic host_wins;
  logic [DATA_W-1:0] rd_capture;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= MAX_CNT) return MAX_CNT;
    return v + 4'd1;
  endfunction

  // The CPU has priority unless the host has been starved up to the limit.
  assign host_wins = host_req && (!cpu_req || (host_wait_cnt == MAX_CNT));
  assign grant     = (state == IDLE) && (cpu_req || host_req);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (grant) state_next = ACCESS;
      ACCESS:   state_next = COMPLETE;
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Arbitration boundary: winner's payload is frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (!rst_n)     owner <= 1'b0;
    else if (grant) owner <= host_wins;
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      we_n_q  <= host_wins ? host_we_n  : cpu_we_n;
      rom_q   <= host_wins ? host_rom   : cpu_rom;
      addr_q  <= host_wins ? host_addr  : cpu_addr;
      wdata_q <= host_wins ? host_wdata : cpu_wdata;
    end
  end

  // The host ages only while it is pending and not the (about to be) owner.
  always_ff @(posedge clk) begin
    if (!rst_n)
      host_wait_cnt <= 4'd0;
    else if (grant && host_wins)
      host_wait_cnt <= 4'd0;
    else if (host_req && !((state != IDLE) && owner))
      host_wait_cnt <= sat_inc(host_wait_cnt);
  end

  // Read capture boundary: ACCESS -> COMPLETE; a disabled device reads as FF.
  assign rd_capture = dev_OE ? dev_DO : 8'hFF;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      host_rdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= (state == ACCESS) && we_n_q && !dev_OE;
      if ((state == ACCESS) && we_n_q) begin
        if (owner) host_rdata <= rd_capture;
        else       cpu_rdata  <= rd_capture;
      end
    end
  end

  // Device port: address/selects held through COMPLETE, write strobe only in ACCESS.
  always_comb begin
    dev_we_n = 1'b1;
    dev_A    = '0;
    dev_DI   = '0;
    dev_RS0  = 1'b1;
    dev_CS1  = 1'b0;
    cpu_ack  = 1'b0;
    host_ack = 1'b0;
    if ((state == ACCESS) || (state == COMPLETE)) begin
      dev_A   = addr_q;
      dev_DI  = wdata_q;
      dev_RS0 = ~rom_q;
      dev_CS1 = rom_q;
    end
    if (state == ACCESS) dev_we_n = we_n_q;
    if (state == COMPLETE) begin
      cpu_ack  = ~owner;
      host_ack = owner;
    end
  end

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// tb_rriot_bus_arbiter
//   Directed bench for rriot_bus_arbiter (HOST_MAX_WAIT = 4): reset values,
//   CPU/host reads and writes, disabled-device reads, CPU/host fairness and
//   reset in the middle of a write.
module tb_rriot_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we_n, cpu_rom;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       host_req, host_we_n, host_rom;
  logic [9:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       dev_we_n;
  logic [9:0] dev_A;
  logic [7:0] dev_DI;
  logic       dev_RS0, dev_CS1;
  logic [7:0] dev_DO;
  logic       dev_OE;
  logic       bus_err;

  int n_chk  = 0;
  int n_pass = 0;

  rriot_bus_arbiter #(.HOST_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_rom(cpu_rom),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we_n(host_we_n), .host_rom(host_rom),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .dev_we_n(dev_we_n), .dev_A(dev_A), .dev_DI(dev_DI),
    .dev_RS0(dev_RS0), .dev_CS1(dev_CS1),
    .dev_DO(dev_DO), .dev_OE(dev_OE), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we_n = 1; cpu_rom = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we_n = 1; host_rom = 0; host_addr = '0; host_wdata = '0;
    dev_DO = 8'h00; dev_OE = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_cpu_ack",  cpu_ack, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_bus_err",  bus_err, 0);
    chk("rst_cpu_rd",   cpu_rdata, 8'h00);
    chk("rst_host_rd",  host_rdata, 8'h00);
    chk("rst_we_n",     dev_we_n, 1);
    chk("rst_A",        dev_A, 10'h000);
    chk("rst_DI",       dev_DI, 8'h00);
    chk("rst_RS0",      dev_RS0, 1);
    chk("rst_CS1",      dev_CS1, 0);
    chk("rst_cnt",      dut.host_wait_cnt, 0);
    rst_n = 1'b1;
    tick();

    // CPU read of RAM 3C5, device drives A5
    cpu_req = 1; cpu_we_n = 1; cpu_rom = 0; cpu_addr = 10'h3C5;
    dev_DO = 8'hA5; dev_OE = 1;
    tick();
    chk("t1_acc_A",    dev_A, 10'h3C5);
    chk("t1_acc_RS0",  dev_RS0, 1);
    chk("t1_acc_CS1",  dev_CS1, 0);
    chk("t1_acc_we_n", dev_we_n, 1);
    chk("t1_acc_ack",  cpu_ack, 0);
    tick();
    chk("t1_cpl_ack",  cpu_ack, 1);
    chk("t1_cpl_hack", host_ack, 0);
    chk("t1_cpl_rd",   cpu_rdata, 8'hA5);
    chk("t1_cpl_err",  bus_err, 0);
    chk("t1_cpl_A",    dev_A, 10'h3C5);
    cpu_req = 0;
    tick();
    chk("t1_idle_ack", cpu_ack, 0);
    chk("t1_idle_A",   dev_A, 10'h000);

    // host read of RAM 011, device drives 3C
    host_req = 1; host_we_n = 1; host_rom = 0; host_addr = 10'h011;
    dev_DO = 8'h3C;
    tick();
    chk("t2_acc_A", dev_A, 10'h011);
    tick();
    chk("t2_cpl_hack", host_ack, 1);
    chk("t2_cpl_ack",  cpu_ack, 0);
    chk("t2_host_rd",  host_rdata, 8'h3C);
    chk("t2_cpu_rd",   cpu_rdata, 8'hA5);
    host_req = 0;
    tick();

    // host write of RAM 300 with 5A; host_rdata must keep 3C
    host_req = 1; host_we_n = 0; host_rom = 0; host_addr = 10'h300; host_wdata = 8'h5A;
    dev_DO = 8'h33;
    tick();
    chk("t3_acc_we_n", dev_we_n, 0);
    chk("t3_acc_DI",   dev_DI, 8'h5A);
    chk("t3_acc_A",    dev_A, 10'h300);
    chk("t3_acc_hack", host_ack, 0);
    tick();
    chk("t3_cpl_hack", host_ack, 1);
    chk("t3_cpl_we_n", dev_we_n, 1);
    chk("t3_host_rd",  host_rdata, 8'h3C);
    chk("t3_cpl_err",  bus_err, 0);
    host_req = 0;
    tick();
    chk("t3_idle_we_n", dev_we_n, 1);

    // CPU read of ROM 012 with device disabled
    cpu_req = 1; cpu_we_n = 1; cpu_rom = 1; cpu_addr = 10'h012;
    dev_OE = 0; dev_DO = 8'h00;
    tick();
    chk("t4_acc_CS1", dev_CS1, 1);
    chk("t4_acc_RS0", dev_RS0, 0);
    tick();
    chk("t4_cpl_ack", cpu_ack, 1);
    chk("t4_cpl_err", bus_err, 1);
    chk("t4_cpu_rd",  cpu_rdata, 8'hFF);
    chk("t4_host_rd", host_rdata, 8'h3C);
    cpu_req = 0; dev_OE = 1;
    tick();
    chk("t4_idle_err", bus_err, 0);

    // both requesters held: cpu, cpu, host, ...
    cpu_req = 1; cpu_we_n = 1; cpu_rom = 0; cpu_addr = 10'h001;
    host_req = 1; host_we_n = 1; host_rom = 0; host_addr = 10'h002;
    dev_DO = 8'h5C;
    for (int k = 0; k < 9; k++) begin
      tick();
      tick();
      chk($sformatf("fair%0d_cpu_ack", k),  cpu_ack,  (k % 3 == 2) ? 0 : 1);
      chk($sformatf("fair%0d_host_ack", k), host_ack, (k % 3 == 2) ? 1 : 0);
      tick();
    end
    cpu_req = 0; host_req = 0;
    tick();

    // reset during ACCESS of a CPU write with the host waiting
    cpu_req = 1; cpu_we_n = 0; cpu_rom = 0; cpu_addr = 10'h055; cpu_wdata = 8'h77;
    host_req = 1; host_we_n = 1;
    tick();
    chk("t6_acc_we_n", dev_we_n, 0);
    chk("t6_acc_cnt",  dut.host_wait_cnt, 1);
    rst_n = 0;
    tick();
    chk("t6_rst_we_n", dev_we_n, 1);
    chk("t6_rst_ack",  cpu_ack, 0);
    chk("t6_rst_hack", host_ack, 0);
    chk("t6_rst_A",    dev_A, 10'h000);
    chk("t6_rst_cnt",  dut.host_wait_cnt, 0);
    cpu_req = 0; host_req = 0;
    rst_n = 1;
    tick();
    tick();
    chk("t6_post_ack",  cpu_ack, 0);
    chk("t6_post_we_n", dev_we_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
